// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit_if : operand, HI/LO and status bundle for muldiv_unit    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_Start;
  logic [1:0]            i_Op;
  logic [DATA_WIDTH-1:0] i_RS_Data;
  logic [DATA_WIDTH-1:0] i_RT_Data;
  logic                  i_MTHI;
  logic                  i_MTLO;
  logic                  o_Busy;
  logic                  o_Done;
  logic [DATA_WIDTH-1:0] o_HI;
  logic [DATA_WIDTH-1:0] o_LO;

  modport master (
    output i_Start, i_Op, i_RS_Data, i_RT_Data, i_MTHI, i_MTLO,
    input  o_Busy, o_Done, o_HI, o_LO
  );

  modport slave (
    input  i_Start, i_Op, i_RS_Data, i_RT_Data, i_MTHI, i_MTLO,
    output o_Busy, o_Done, o_HI, o_LO
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit : iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO regs  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  wire logic         i_Clk,
  input  wire logic         reset,
  muldiv_unit_if.slave      bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         b_q, b_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic                 a_neg, b_neg;
  logic [W-1:0]         a_mag, b_mag;
  logic [W:0]           mul_sum;
  logic [W:0]           div_diff;
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         quot_fix;
  logic [W-1:0]         rem_fix;

  assign op_signed = ~bus.i_Op[0];
  assign a_neg     = op_signed & bus.i_RS_Data[W-1];
  assign b_neg     = op_signed & bus.i_RT_Data[W-1];
  assign a_mag     = a_neg ? -bus.i_RS_Data : bus.i_RS_Data;
  assign b_mag     = b_neg ? -bus.i_RT_Data : bus.i_RT_Data;

  // Multiply: acc = {partial, multiplier}; add multiplicand when LSB set, then shift right.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
  // Divide: acc = {remainder, dividend/quotient}; trial-subtract on the left-shifted remainder.
  assign div_diff  = acc_q[2*W-1:W-1] - {1'b0, b_q};

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quot_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          is_div_d   = bus.i_Op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (bus.i_RT_Data == '0);
          cnt_d      = '0;
          state_d    = ST_RUN;
          if (bus.i_Op[1]) begin
            acc_d = {{W{1'b0}}, a_mag};
            b_d   = b_mag;
          end else begin
            acc_d = {{W{1'b0}}, b_mag};
            b_d   = a_mag;
          end
        end else begin
          if (bus.i_MTHI) hi_d = bus.i_RS_Data;
          if (bus.i_MTLO) lo_d = bus.i_RS_Data;
        end
      end

      ST_RUN: begin
        if (is_div_q) begin
          if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          else              acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_STEP) state_d = ST_FIXUP;
      end

      ST_FIXUP: begin
        // Divide-by-zero leaves the dividend in the remainder, so HI already matches RS.
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div_zero_q ? {W{1'b1}} : quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_Busy = (state_q != ST_IDLE);
  assign bus.o_Done = done_q;
  assign bus.o_HI   = hi_q;
  assign bus.o_LO   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit : scoreboard bench for muldiv_unit                    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .i_Clk (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural reference: plain 64-bit integer arithmetic.
  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    res_t            m;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: begin p = sa * sb; m.hi = p[63:32]; m.lo = p[31:0]; end
      2'd1: begin up = ua * ub; m.hi = up[63:32]; m.lo = up[31:0]; end
      2'd2: begin
        if (b == 32'd0) begin m.hi = a; m.lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; m.hi = r[31:0]; m.lo = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin m.hi = a; m.lo = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; ur = ua % ub; m.hi = ur[31:0]; m.lo = uq[31:0]; end
      end
    endcase
    return m;
  endfunction

  always @(negedge clk) begin
    if (bus.o_Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", {32'b0, bus.o_HI}, {32'b0, mon_e.hi});
        check("lo", {32'b0, bus.o_LO}, {32'b0, mon_e.lo});
        check("busy_in_done", {63'b0, bus.o_Busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic with_mt);
    @(negedge clk);
    bus.i_Start   = 1'b1;
    bus.i_Op      = op;
    bus.i_RS_Data = a;
    bus.i_RT_Data = b;
    bus.i_MTHI    = with_mt;
    bus.i_MTLO    = with_mt;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.i_Start   = 1'b0;
    bus.i_MTHI    = 1'b0;
    bus.i_MTLO    = 1'b0;
    bus.i_Op      = 2'($urandom_range(0, 3));
    bus.i_RS_Data = $urandom;
    bus.i_RT_Data = $urandom;
  endtask

  // Called on the first negedge after acceptance; counts cycles to o_Done.
  task automatic wait_done(output int lat, output int busy_cnt, output int hold_err);
    logic [31:0] hi0, lo0;
    hi0 = bus.o_HI;
    lo0 = bus.o_LO;
    lat = 1;
    busy_cnt = 0;
    hold_err = 0;
    while (bus.o_Done !== 1'b1 && lat < 40) begin
      if (bus.o_Busy === 1'b1) busy_cnt++;
      if (bus.o_HI !== hi0 || bus.o_LO !== lo0) hold_err++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic with_mt);
    int lat, bc, he;
    issue(op, a, b, with_mt);
    wait_done(lat, bc, he);
    check("latency", 64'(lat), 64'd34);
    check("busy_cycles", 64'(bc), 64'd33);
    check("hilo_hold", 64'(he), 64'd0);
  endtask

  initial begin
    int lat, bc, he;
    logic [31:0] hi0;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    res_t        r1;

    bus.i_Start = 1'b0; bus.i_Op = 2'd0; bus.i_RS_Data = '0; bus.i_RT_Data = '0;
    bus.i_MTHI = 1'b0;  bus.i_MTLO = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'b0, bus.o_HI}, 64'd0);
    check("rst_lo", {32'b0, bus.o_LO}, 64'd0);
    check("rst_busy", {63'b0, bus.o_Busy}, 64'd0);
    check("rst_done", {63'b0, bus.o_Done}, 64'd0);
    rst_n = 1'b1;

    do_op(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'd3, 32'd100, 32'd0, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // Abandoned operation: mid-run start/MTHI/operand changes ignored, then reset.
    @(negedge clk);
    bus.i_Start = 1'b1; bus.i_Op = 2'd0; bus.i_RS_Data = 32'd3; bus.i_RT_Data = 32'd5;
    @(negedge clk);
    bus.i_Start = 1'b0;
    hi0 = bus.o_HI;
    repeat (8) @(negedge clk);
    bus.i_Start = 1'b1; bus.i_Op = 2'd2; bus.i_MTHI = 1'b1;
    bus.i_RS_Data = 32'h0000_1234; bus.i_RT_Data = 32'h0000_0007;
    @(negedge clk);
    bus.i_Start = 1'b0; bus.i_MTHI = 1'b0;
    check("busy_ignore_start", {63'b0, bus.o_Busy}, 64'd1);
    check("mthi_ignored_busy", {32'b0, bus.o_HI}, {32'b0, hi0});
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_hi", {32'b0, bus.o_HI}, 64'd0);
    check("abort_lo", {32'b0, bus.o_LO}, 64'd0);
    check("abort_busy", {63'b0, bus.o_Busy}, 64'd0);
    repeat (40) @(negedge clk);

    // MTHI/MTLO in IDLE.
    bus.i_MTHI = 1'b1; bus.i_RS_Data = 32'h0000_1234;
    @(negedge clk);
    bus.i_MTHI = 1'b0; bus.i_MTLO = 1'b1; bus.i_RS_Data = 32'h0000_5678;
    @(negedge clk);
    bus.i_MTLO = 1'b0;
    check("mthi", {32'b0, bus.o_HI}, 64'h1234);
    check("mtlo", {32'b0, bus.o_LO}, 64'h5678);
    bus.i_MTHI = 1'b1; bus.i_MTLO = 1'b1; bus.i_RS_Data = 32'hCAFE_F00D;
    @(negedge clk);
    bus.i_MTHI = 1'b0; bus.i_MTLO = 1'b0;
    check("mt_both_hi", {32'b0, bus.o_HI}, 64'hCAFE_F00D);
    check("mt_both_lo", {32'b0, bus.o_LO}, 64'hCAFE_F00D);
    check("mt_no_done", {63'b0, bus.o_Done}, 64'd0);

    // Back-to-back: start held high through the first o_Done cycle.
    @(negedge clk);
    bus.i_Start = 1'b1; bus.i_Op = 2'd0;
    bus.i_RS_Data = 32'hFFFF_FFF0; bus.i_RT_Data = 32'h0000_0011;
    r1 = model(2'd0, 32'hFFFF_FFF0, 32'h0000_0011);
    exp_q.push_back(r1);
    exp_q.push_back(model(2'd3, 32'hDEAD_BEEF, 32'h0000_0123));
    @(negedge clk);
    bus.i_Op = 2'd3; bus.i_RS_Data = 32'hDEAD_BEEF; bus.i_RT_Data = 32'h0000_0123;
    wait_done(lat, bc, he);
    check("b2b_first_latency", 64'(lat), 64'd34);
    @(negedge clk);
    bus.i_Start = 1'b0;
    check("b2b_second_busy", {63'b0, bus.o_Busy}, 64'd1);
    check("b2b_first_hi_kept", {32'b0, bus.o_HI}, {32'b0, r1.hi});
    check("b2b_first_lo_kept", {32'b0, bus.o_LO}, {32'b0, r1.lo});
    wait_done(lat, bc, he);
    check("b2b_second_latency", 64'(lat), 64'd34);
    check("b2b_hold", 64'(he), 64'd0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
